// File: rtl/hazard_ctrl_if.sv
// Decode-side handshake between the pipeline and the hazard controller:
// decode operands in, bypass selects, stall/flush and event counters out.
interface hazard_ctrl_if #(
  parameter int ADDR_SIZE = 5,
  parameter int CNT_W     = 16
);
  logic                 D_valid;
  logic [ADDR_SIZE-1:0] D_ra;
  logic [ADDR_SIZE-1:0] D_rb;
  logic                 D_use_ra;
  logic                 D_use_rb;
  logic [ADDR_SIZE-1:0] D_rd;
  logic                 D_we;
  logic                 D_ld;
  logic                 brn_taken;
  logic                 ext_stall;
  logic [1:0]           EX_D_bp;
  logic [1:0]           MEM_D_bp;
  logic [1:0]           WB_D_bp;
  logic                 D_stall;
  logic                 D_flush;
  logic [CNT_W-1:0]     stall_cnt;
  logic [CNT_W-1:0]     flush_cnt;

  modport master (
    output D_valid, D_ra, D_rb, D_use_ra, D_use_rb, D_rd, D_we, D_ld,
    output brn_taken, ext_stall,
    input  EX_D_bp, MEM_D_bp, WB_D_bp, D_stall, D_flush, stall_cnt, flush_cnt
  );

  modport slave (
    input  D_valid, D_ra, D_rb, D_use_ra, D_use_rb, D_rd, D_we, D_ld,
    input  brn_taken, ext_stall,
    output EX_D_bp, MEM_D_bp, WB_D_bp, D_stall, D_flush, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadows EX/MEM/WB destinations to select bypass
// sources, detects load-use stalls, handles branch flushes and counts events.
module hazard_ctrl #(
  parameter int ADDR_SIZE = 5,
  parameter int CNT_W     = 16
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave bus
);
  typedef struct packed {
    logic                 valid;
    logic [ADDR_SIZE-1:0] rd;
    logic                 we;
    logic                 ld;
  } slot_t;

  slot_t            ex_r, mem_r, wb_r, dec_s;
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;
  logic             ex_a_s, ex_b_s, mem_a_s, mem_b_s, wb_a_s, wb_b_s;
  logic             lu_s;

  // Register x0 is hardwired, so a write to it never produces a value to forward.
  function automatic logic writing(input slot_t s);
    return s.valid && s.we && (s.rd != {ADDR_SIZE{1'b0}});
  endfunction

  function automatic logic hits(input slot_t s, input logic [ADDR_SIZE-1:0] r);
    return writing(s) && (s.rd == r);
  endfunction

  // Source matches against each shadow slot, load-use detection and next EX entry.
  always_comb begin
    ex_a_s  = 1'b0;
    ex_b_s  = 1'b0;
    mem_a_s = 1'b0;
    mem_b_s = 1'b0;
    wb_a_s  = 1'b0;
    wb_b_s  = 1'b0;
    lu_s    = 1'b0;
    dec_s   = '0;
    if (bus.D_valid) begin
      ex_a_s  = bus.D_use_ra && hits(ex_r,  bus.D_ra);
      ex_b_s  = bus.D_use_rb && hits(ex_r,  bus.D_rb);
      mem_a_s = bus.D_use_ra && hits(mem_r, bus.D_ra);
      mem_b_s = bus.D_use_rb && hits(mem_r, bus.D_rb);
      wb_a_s  = bus.D_use_ra && hits(wb_r,  bus.D_ra);
      wb_b_s  = bus.D_use_rb && hits(wb_r,  bus.D_rb);
    end else begin
      ex_a_s  = 1'b0;
    end
    lu_s = ex_r.ld && (ex_a_s || ex_b_s);
    if (lu_s || bus.brn_taken) begin
      dec_s = '0;
    end else begin
      dec_s = '{valid: bus.D_valid, rd: bus.D_rd, we: bus.D_we, ld: bus.D_ld};
    end
  end

  // An EX load match blocks MEM/WB for that source even though EX cannot forward it.
  assign bus.EX_D_bp  = {ex_a_s && !ex_r.ld, ex_b_s && !ex_r.ld};
  assign bus.MEM_D_bp = {mem_a_s && !ex_a_s, mem_b_s && !ex_b_s};
  assign bus.WB_D_bp  = {wb_a_s && !ex_a_s && !mem_a_s, wb_b_s && !ex_b_s && !mem_b_s};
  assign bus.D_stall  = lu_s || bus.ext_stall;
  assign bus.D_flush  = bus.brn_taken && !bus.ext_stall;
  assign bus.stall_cnt = stall_cnt_r;
  assign bus.flush_cnt = flush_cnt_r;

  // Slot advance and saturating event counters; everything freezes under ext_stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_r        <= '0;
      mem_r       <= '0;
      wb_r        <= '0;
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else if (!bus.ext_stall) begin
      wb_r  <= mem_r;
      mem_r <= ex_r;
      ex_r  <= dec_s;
      if (lu_s && !bus.brn_taken && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (bus.brn_taken && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end else begin
      ex_r        <= ex_r;
      mem_r       <= mem_r;
      wb_r        <= wb_r;
      stall_cnt_r <= stall_cnt_r;
      flush_cnt_r <= flush_cnt_r;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (CNT_W=4 build so counter saturation is reachable).
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.ADDR_SIZE(5), .CNT_W(4)) bus ();
  hazard_ctrl #(.ADDR_SIZE(5), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic v, input logic [4:0] ra, input logic [4:0] rb,
                       input logic ua, input logic ub, input logic [4:0] rd,
                       input logic we, input logic ld);
    bus.D_valid = v;  bus.D_ra = ra; bus.D_rb = rb;
    bus.D_use_ra = ua; bus.D_use_rb = ub;
    bus.D_rd = rd; bus.D_we = we; bus.D_ld = ld;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bp(input string tag, input logic [1:0] ex, input logic [1:0] mem,
                        input logic [1:0] wb, input logic st);
    chk({tag, "_ex"},    bus.EX_D_bp,  ex);
    chk({tag, "_mem"},   bus.MEM_D_bp, mem);
    chk({tag, "_wb"},    bus.WB_D_bp,  wb);
    chk({tag, "_stall"}, bus.D_stall,  st);
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.brn_taken = 1'b0; bus.ext_stall = 1'b0;
    set_d(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.brn_taken = 1'b0; bus.ext_stall = 1'b0;
    set_d(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick(); tick();
    // reset state
    chk_bp("rst", 2'b00, 2'b00, 2'b00, 1'b0);
    chk("rst_scnt", bus.stall_cnt, 4'h0);
    chk("rst_fcnt", bus.flush_cnt, 4'h0);
    chk("rst_flush0", bus.D_flush, 1'b0);
    bus.ext_stall = 1'b1; bus.brn_taken = 1'b1; #1;
    chk("rst_stall_ext", bus.D_stall, 1'b1);
    chk("rst_flush_ext", bus.D_flush, 1'b0);
    bus.ext_stall = 1'b0; #1;
    chk("rst_flush_brn", bus.D_flush, 1'b1);
    tick();
    chk("rst_over_brn", bus.flush_cnt, 4'h0);
    bus.brn_taken = 1'b0; rst = 1'b0;

    // ALU chain: add x3 ; add x4,x3,x3
    set_d(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    chk_bp("alu0", 2'b00, 2'b00, 2'b00, 1'b0);
    tick();
    set_d(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    chk_bp("alu1", 2'b11, 2'b00, 2'b00, 1'b0);
    tick();
    set_d(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    chk_bp("alu2", 2'b01, 2'b10, 2'b00, 1'b0);
    tick();
    set_d(1'b1, 5'd4, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    chk_bp("alu3", 2'b00, 2'b10, 2'b01, 1'b0);
    set_d(1'b1, 5'd4, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    chk_bp("alu3_nouse", 2'b00, 2'b10, 2'b00, 1'b0);
    set_d(1'b0, 5'd4, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    chk_bp("alu3_novalid", 2'b00, 2'b00, 2'b00, 1'b0);

    // Load-use: lw x5 ; add x6,x5,x0
    do_reset();
    set_d(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    set_d(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    chk_bp("lu1", 2'b00, 2'b00, 2'b00, 1'b1);
    tick();
    chk_bp("lu2", 2'b00, 2'b10, 2'b00, 1'b0);
    chk("lu_scnt", bus.stall_cnt, 4'h1);

    // Priority: x7 in WB, MEM and EX
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_d(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
      tick();
    end
    set_d(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0);
    chk_bp("prio_ra", 2'b10, 2'b00, 2'b00, 1'b0);
    set_d(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    chk_bp("prio_both", 2'b11, 2'b00, 2'b00, 1'b0);
    set_d(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1);
    tick();
    set_d(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0);
    chk_bp("prio_exld", 2'b00, 2'b00, 2'b00, 1'b1);

    // x0 destinations never forward
    do_reset();
    set_d(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0); tick();
    set_d(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0); tick();
    set_d(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1); tick();
    set_d(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    chk_bp("x0", 2'b00, 2'b00, 2'b00, 1'b0);

    // Branch + load-use in the same cycle
    do_reset();
    set_d(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    set_d(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
    bus.brn_taken = 1'b1; #1;
    chk("brlu_flush", bus.D_flush, 1'b1);
    chk("brlu_stall", bus.D_stall, 1'b1);
    tick();
    bus.brn_taken = 1'b0;
    chk("brlu_fcnt", bus.flush_cnt, 4'h1);
    chk("brlu_scnt", bus.stall_cnt, 4'h0);
    set_d(1'b1, 5'd9, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    chk_bp("brlu_bubble", 2'b00, 2'b01, 2'b00, 1'b0);

    // ext_stall held 3 cycles during a load-use hazard
    do_reset();
    set_d(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    set_d(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
    bus.ext_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.brn_taken = (i == 1); #1;
      chk_bp("ext_hold", 2'b00, 2'b00, 2'b00, 1'b1);
      chk("ext_flush", bus.D_flush, 1'b0);
      tick();
      chk("ext_scnt", bus.stall_cnt, 4'h0);
      chk("ext_fcnt", bus.flush_cnt, 4'h0);
    end
    bus.ext_stall = 1'b0; bus.brn_taken = 1'b0; #1;
    chk_bp("ext_rel", 2'b00, 2'b00, 2'b00, 1'b1);
    tick();
    chk_bp("ext_resume", 2'b00, 2'b10, 2'b00, 1'b0);
    chk("ext_scnt1", bus.stall_cnt, 4'h1);
    rst = 1'b1; bus.ext_stall = 1'b1; bus.brn_taken = 1'b1;
    tick();
    rst = 1'b0; bus.ext_stall = 1'b0; bus.brn_taken = 1'b0;
    set_d(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    chk_bp("midrst", 2'b00, 2'b00, 2'b00, 1'b0);
    chk("midrst_scnt", bus.stall_cnt, 4'h0);
    chk("midrst_fcnt", bus.flush_cnt, 4'h0);

    // Counter saturation: 18 load-use stalls, 17 flushes on a 4-bit counter
    do_reset();
    for (int i = 0; i < 18; i++) begin
      set_d(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);
      tick();
      set_d(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
      tick();
      if (i == 14) chk("sat_scnt15", bus.stall_cnt, 4'hF);
    end
    chk("sat_scnt", bus.stall_cnt, 4'hF);
    set_d(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    bus.brn_taken = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    bus.brn_taken = 1'b0;
    chk("sat_fcnt", bus.flush_cnt, 4'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
